// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data-memory controller with fixed access latency.
//
// Purpose:
//   Accepts one byte/half/word load or store at a time. After the request is
//   accepted it waits LAT cycles, then performs the access. It then issues a
//   one-cycle response carrying the sign- or zero-extended load data.
//   The memory is 2**ADDR_W 32-bit words. It is indexed by req_addr[ADDR_W+1:2],
//   so the upper address bits are ignored and addresses wrap.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-low reset
//   req_valid    in   request present
//   req_ready    out  high in IDLE and RESP; accept = req_valid & req_ready
//   req_we       in   1 = store, 0 = load
//   req_size     in   00 byte, 01 half, 10/11 word
//   req_unsigned in   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     in   byte address
//   req_wdata    in   store data, right-justified
//   rsp_valid    out  one-cycle completion pulse
//   rsp_rdata    out  extended load data (0 for stores), held until next response
//   rsp_err      out  misaligned-access flag, held until next response
//
// Configuration:
//   DMEM_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//     flagged via rsp_err. They do not write and return zero data. When the
//     macro is undefined, rsp_err is always 0 and misaligned addresses are
//     forced down to natural alignment.

module data_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              we_reg, uns_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;

  // Response-side copies, so a new request accepted in RESP cannot disturb
  // the data of the response currently being held.
  logic              rsp_valid_reg, rsp_err_reg, rsp_load_reg, rsp_uns_reg;
  logic [1:0]        rsp_size_reg, rsp_lo_reg;
  logic [31:0]       rd_word_reg;

  logic              accept, access, misalign, do_write;
  logic              is_byte, is_half, is_word;
  logic [3:0]        lane_en;
  logic [3:0][7:0]   wr_lane;
  logic [ADDR_W-1:0] idx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_reg == IDLE) || (state_reg == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state_reg == WAIT) && (cnt_reg == 3'd0);
  assign idx       = addr_reg[ADDR_W+1:2];

  assign is_byte = (size_reg == 2'b00);
  assign is_half = (size_reg == 2'b01);
  assign is_word = size_reg[1];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (is_half && addr_reg[0]) || (is_word && (addr_reg[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane selection naturally ignores addr[0] for halves and addr[1:0] for
  // words, which gives the forced alignment when misalignment is not flagged.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = is_word
                         | (is_half & (addr_reg[1] == LANE[1]))
                         | (is_byte & (addr_reg[1:0] == LANE));
      assign wr_lane[gi] = is_word ? wdata_reg[8*gi +: 8]
                         : is_half ? (LANE[0] ? wdata_reg[15:8] : wdata_reg[7:0])
                         : wdata_reg[7:0];
    end
  endgenerate

  // Qualifying with rst keeps a request that is in flight at reset from
  // writing on the reset edge.
  assign do_write = access && we_reg && !misalign && rst;

  // Memory contents survive reset; the read is registered at the access edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wr_lane[i];
      end
    end
    if (access) rd_word_reg <= mem[idx];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (accept) state_next = WAIT;
      WAIT: if (cnt_reg == 3'd0) state_next = RESP;
      RESP: state_next = accept ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
    if (accept) cnt_next = 3'(LAT);
    else if (state_reg == WAIT && cnt_reg != 3'd0) cnt_next = cnt_reg - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      uns_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      rsp_uns_reg   <= 1'b0;
      rsp_size_reg  <= 2'b00;
      rsp_lo_reg    <= 2'b00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= access;
      if (accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        addr_reg  <= req_addr[ADDR_W+1:0];
        wdata_reg <= req_wdata;
      end
      if (access) begin
        rsp_err_reg  <= misalign;
        rsp_load_reg <= !we_reg && !misalign;
        rsp_uns_reg  <= uns_reg;
        rsp_size_reg <= size_reg;
        rsp_lo_reg   <= addr_reg[1:0];
      end
    end
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign rd_byte = rd_word_reg[{rsp_lo_reg, 3'b000} +: 8];
  assign rd_half = rsp_lo_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

  always_comb begin
    rd_ext = rd_word_reg;
    case (rsp_size_reg)
      2'b00:   rd_ext = {{24{~rsp_uns_reg & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{~rsp_uns_reg & rd_half[15]}}, rd_half};
      default: rd_ext = rd_word_reg;
    endcase
  end

  // Gating with rsp_load_reg yields 0 after reset, for stores and for
  // flagged accesses without needing to reset the RAM output register.
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_load_reg ? rd_ext : 32'd0;
  assign rsp_err   = rsp_err_reg;

endmodule
